// File: rtl/bus_pkg.sv
// Shared bus definitions for the APU DMA arbiter: read/write encoding,
// register addresses, FSM state and bus-owner encodings.
package bus_pkg;

    localparam logic BUS_READ  = 1'b1;
    localparam logic BUS_WRITE = 1'b0;

    localparam logic [15:0] DMA_REG  = 16'h4014;
    localparam logic [15:0] OAM_DATA = 16'h2004;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        OAM_RD,
        OAM_WR,
        DMC_RD,
        DMC_ALIGN
    } dma_state_t;

    typedef enum logic [2:0] {
        OWN_CPU,
        OWN_DUMMY,
        OWN_DMC,
        OWN_OAM_RD,
        OWN_OAM_WR
    } bus_owner_t;

endpackage

// File: rtl/apu_dma_arbiter_if.sv
// System bus between the arbiter (master) and the memory/PPU decoder (slave).
// bus_rdata is valid at the clk edge that ends the cycle.
interface apu_dma_arbiter_if;

    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_rw;
    logic [7:0]  bus_rdata;

    modport master (
        output bus_addr,
        output bus_wdata,
        output bus_rw,
        input  bus_rdata
    );

    modport slave (
        input  bus_addr,
        input  bus_wdata,
        input  bus_rw,
        output bus_rdata
    );

endinterface

// File: rtl/bus_mux.sv
// Combinational owner select of the system bus address, write data and direction.
module bus_mux
    import bus_pkg::*;
#(
    parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA
) (
    input  bus_owner_t  owner,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_rw,
    input  logic [15:0] dmc_addr,
    input  logic [15:0] oam_addr,
    input  logic [7:0]  latch_data,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_rw
);

    // Dummy cycles fall through the defaults: a read at the CPU's address.
    always_comb begin
        bus_addr  = cpu_addr;
        bus_wdata = latch_data;
        bus_rw    = BUS_READ;
        case (owner)
            OWN_CPU: begin
                bus_wdata = cpu_dout;
                bus_rw    = cpu_rw;
            end
            OWN_DMC:    bus_addr = dmc_addr;
            OWN_OAM_RD: bus_addr = oam_addr;
            OWN_OAM_WR: begin
                bus_addr = OAM_DATA_ADDR;
                bus_rw   = BUS_WRITE;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/apu_dma_arbiter.sv
// Arbitrates the system bus between the 6502 core, OAM sprite DMA and DMC sample
// fetches; stalls the core via cpu_rdy and slots DMA reads into get cycles.
module apu_dma_arbiter
    import bus_pkg::*;
#(
    parameter logic [15:0] DMA_REG  = bus_pkg::DMA_REG,
    parameter logic [15:0] OAM_DATA = bus_pkg::OAM_DATA,
    parameter int          OAM_LEN  = 256
) (
    input  logic                      clk,
    input  logic                      n_reset,
    input  logic [15:0]               cpu_addr,
    input  logic [7:0]                cpu_dout,
    input  logic                      cpu_rw,
    output logic                      cpu_rdy,
    apu_dma_arbiter_if.master         bus,
    // dmc_req is a level request; dmc_valid pulses for one cycle after the
    // fetch and the requester must drop dmc_req within that same cycle.
    input  logic                      dmc_req,
    input  logic [15:0]               dmc_addr,
    output logic [7:0]                dmc_data,
    output logic                      dmc_valid,
    output logic                      busy,
    output dma_state_t                dbg_state
);

    localparam logic [7:0] LAST_IDX = 8'(OAM_LEN - 1);

    dma_state_t state;
    dma_state_t state_nxt;
    dma_state_t slot_nxt;
    bus_owner_t owner;

    logic       parity;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] data;
    logic       oam_pend;
    logic       trigger;

    assign trigger   = (state == IDLE) && (cpu_rw == BUS_WRITE) && (cpu_addr == DMA_REG);
    assign dbg_state = state;

    // Decision taken whenever the next cycle is a get slot; DMC wins over OAM.
    always_comb begin
        slot_nxt = IDLE;
        if (dmc_req)       slot_nxt = DMC_RD;
        else if (oam_pend) slot_nxt = OAM_RD;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:      state_nxt = (trigger || dmc_req) ? HALT : IDLE;
            HALT:      state_nxt = parity ? slot_nxt : ALIGN;
            ALIGN:     state_nxt = slot_nxt;
            DMC_ALIGN: state_nxt = slot_nxt;
            DMC_RD:    state_nxt = oam_pend ? DMC_ALIGN : IDLE;
            OAM_RD:    state_nxt = OAM_WR;
            OAM_WR:    state_nxt = (idx == LAST_IDX) ? IDLE : slot_nxt;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        owner   = OWN_DUMMY;
        cpu_rdy = 1'b0;
        busy    = 1'b1;
        case (state)
            IDLE: begin
                owner   = OWN_CPU;
                cpu_rdy = 1'b1;
                busy    = 1'b0;
            end
            DMC_RD:  owner = OWN_DMC;
            OAM_RD:  owner = OWN_OAM_RD;
            OAM_WR:  owner = OWN_OAM_WR;
            default: owner = OWN_DUMMY;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            parity    <= 1'b0;
            page      <= 8'h00;
            idx       <= 8'h00;
            data      <= 8'h00;
            oam_pend  <= 1'b0;
            dmc_data  <= 8'h00;
            dmc_valid <= 1'b0;
        end else begin
            parity    <= ~parity;
            dmc_valid <= (state == DMC_RD);
            if (trigger) begin
                page     <= cpu_dout;
                idx      <= 8'h00;
                oam_pend <= 1'b1;
            end
            if (state == OAM_RD) data <= bus.bus_rdata;
            if (state == DMC_RD) dmc_data <= bus.bus_rdata;
            if (state == OAM_WR) begin
                if (idx == LAST_IDX) oam_pend <= 1'b0;
                else                 idx <= idx + 8'h01;
            end
        end
    end

    bus_mux #(
        .OAM_DATA_ADDR (OAM_DATA)
    ) u_bus_mux (
        .owner      (owner),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .cpu_rw     (cpu_rw),
        .dmc_addr   (dmc_addr),
        .oam_addr   ({page, idx}),
        .latch_data (data),
        .bus_addr   (bus.bus_addr),
        .bus_wdata  (bus.bus_wdata),
        .bus_rw     (bus.bus_rw)
    );

endmodule

// File: tb/tb_apu_dma_arbiter.sv
// Randomized bench for apu_dma_arbiter: a behavioural bus monitor and an
// expected-byte queue predict OAM transfers, DMC fetches and stall lengths.
module tb_apu_dma_arbiter;
    import bus_pkg::*;

    localparam int OAM_LEN = 256;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_rw;
    logic        cpu_rdy;
    logic        dmc_req;
    logic [15:0] dmc_addr;
    logic [7:0]  dmc_data;
    logic        dmc_valid;
    logic        busy;
    dma_state_t  dbg_state;

    apu_dma_arbiter_if bus();

    apu_dma_arbiter dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .cpu_addr  (cpu_addr),
        .cpu_dout  (cpu_dout),
        .cpu_rw    (cpu_rw),
        .cpu_rdy   (cpu_rdy),
        .bus       (bus),
        .dmc_req   (dmc_req),
        .dmc_addr  (dmc_addr),
        .dmc_data  (dmc_data),
        .dmc_valid (dmc_valid),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset / cycle parity ----------------
    always #5 clk = ~clk;

    int unsigned cyc;
    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // Memory contents seen on the bus: a fixed scramble of the address.
    logic [7:0] salt;
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ salt ^ 8'h5A;
    endfunction
    assign bus.bus_rdata = mem_byte(bus.bus_addr);

    // ---------------- checker ----------------
    int checks = 0;
    int failures = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [7:0]  exp_q[$];
    logic [7:0]  cur_page;
    logic [15:0] dmc_target;
    int          dmc_at_idx;
    int          stall_cnt, oam_rd_cnt, oam_wr_cnt, dummy_cnt;
    int          dmc_rd_cnt, dmc_valid_cnt, rd_at_dmc;
    int unsigned dmc_rd_cyc;
    bit          mon_en = 1'b0;

    task automatic clear_counts();
        stall_cnt = 0; oam_rd_cnt = 0; oam_wr_cnt = 0; dummy_cnt = 0;
        dmc_rd_cnt = 0; dmc_valid_cnt = 0; rd_at_dmc = -1;
    endtask

    always @(negedge clk) begin
        if (n_reset && mon_en) begin
            check("busy_vs_rdy", busy, !cpu_rdy);
            if (!cpu_rdy) begin
                stall_cnt++;
                if (bus.bus_rw == BUS_WRITE) begin
                    oam_wr_cnt++;
                    check("wr_addr", bus.bus_addr, OAM_DATA);
                    check("wr_parity", cyc[0], 1);
                    check("wr_q_nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) check("wr_data", bus.bus_wdata, exp_q.pop_front());
                end else if (bus.bus_addr == cpu_addr) begin
                    dummy_cnt++;
                end else if (dmc_req && bus.bus_addr == dmc_target) begin
                    dmc_rd_cnt++;
                    rd_at_dmc  = oam_rd_cnt;
                    dmc_rd_cyc = cyc;
                    check("dmc_parity", cyc[0], 0);
                end else begin
                    check("rd_addr", bus.bus_addr, {cur_page, oam_rd_cnt[7:0]});
                    check("rd_parity", cyc[0], 0);
                    if (oam_rd_cnt == dmc_at_idx) dmc_req = 1'b1;
                    oam_rd_cnt++;
                end
            end
            if (dmc_valid) begin
                dmc_valid_cnt++;
                check("dmc_data", dmc_data, mem_byte(dmc_target));
                check("dmc_valid_lat", cyc - dmc_rd_cyc, 1);
                dmc_req = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Make the cycle being driven now have parity p.
    task automatic align_to(input bit p);
        if (cyc[0] != p) step(1);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            step(1);
            n++;
        end
        check("idle_reached", busy, 0);
    endtask

    // dmc_idx: -1 none, -2 together with the trigger, else OAM index after whose read it rises.
    task automatic trigger_oam(input logic [7:0] page, input bit halt_par, input int dmc_idx,
                               input logic [15:0] daddr);
        clear_counts();
        cur_page   = page;
        dmc_at_idx = dmc_idx;
        dmc_target = daddr;
        dmc_addr   = daddr;
        for (int i = 0; i < OAM_LEN; i++) exp_q.push_back(mem_byte({page, 8'(i)}));
        align_to(!halt_par);
        cpu_addr = DMA_REG;
        cpu_rw   = BUS_WRITE;
        cpu_dout = page;
        if (dmc_idx == -2) dmc_req = 1'b1;
        #1;
        check("trig_bus_addr", bus.bus_addr, DMA_REG);
        check("trig_bus_rw", bus.bus_rw, BUS_WRITE);
        check("trig_bus_wdata", bus.bus_wdata, page);
        check("trig_cpu_rdy", cpu_rdy, 1);
        step(1);
        cpu_addr = 16'h8000;
        cpu_rw   = BUS_READ;
        cpu_dout = 8'($urandom_range(0, 255));
    endtask

    task automatic run_oam(input logic [7:0] page, input bit halt_par, input int dmc_idx,
                           input logic [15:0] daddr);
        int has_dmc;
        trigger_oam(page, halt_par, dmc_idx, daddr);
        wait_idle(2000);
        step(2);
        has_dmc = (dmc_idx != -1) ? 1 : 0;
        check("oam_stall", stall_cnt, 2 * OAM_LEN + 1 + (halt_par ? 0 : 1) + 2 * has_dmc);
        check("oam_reads", oam_rd_cnt, OAM_LEN);
        check("oam_writes", oam_wr_cnt, OAM_LEN);
        check("oam_q_empty", exp_q.size(), 0);
        check("dummy_cycles", dummy_cnt, 1 + (halt_par ? 0 : 1) + has_dmc);
        check("dmc_reads", dmc_rd_cnt, has_dmc);
        check("dmc_valids", dmc_valid_cnt, has_dmc);
        if (has_dmc != 0) check("dmc_slot", rd_at_dmc, (dmc_idx == -2) ? 0 : dmc_idx + 1);
        exp_q.delete();
    endtask

    task automatic run_dmc(input bit halt_par, input logic [15:0] daddr);
        clear_counts();
        dmc_at_idx = -1;
        dmc_target = daddr;
        dmc_addr   = daddr;
        align_to(!halt_par);
        dmc_req = 1'b1;
        step(1);
        wait_idle(50);
        step(3);
        check("dmc_stall", stall_cnt, halt_par ? 2 : 3);
        check("dmc_only_reads", dmc_rd_cnt, 1);
        check("dmc_only_valids", dmc_valid_cnt, 1);
        check("dmc_only_writes", oam_wr_cnt, 0);
        check("dmc_req_dropped", dmc_req, 0);
    endtask

    task automatic run_reset_abort(input logic [7:0] page);
        int n;
        trigger_oam(page, 1'b1, -1, 16'hC000);
        n = 0;
        while (oam_rd_cnt != 'h81 && n < 1000) begin
            step(1);
            n++;
        end
        check("abort_reached_80", oam_rd_cnt, 'h81);
        check("abort_writes_before", oam_wr_cnt, 'h80);
        n_reset = 1'b0;
        #1;
        check("abort_cpu_rdy", cpu_rdy, 1);
        check("abort_busy", busy, 0);
        check("abort_bus_rw", bus.bus_rw, BUS_READ);
        check("abort_dmc_valid", dmc_valid, 0);
        step(2);
        n_reset = 1'b1;
        exp_q.delete();
        clear_counts();
        step(600);
        check("post_abort_writes", oam_wr_cnt, 0);
        check("post_abort_stall", stall_cnt, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int idx_r;
        salt       = 8'($urandom_range(0, 255));
        cpu_addr   = 16'h8000;
        cpu_rw     = BUS_READ;
        cpu_dout   = 8'h00;
        dmc_req    = 1'b0;
        dmc_addr   = 16'hC000;
        dmc_target = 16'hC000;
        dmc_at_idx = -1;
        cur_page   = 8'h00;
        clear_counts();
        n_reset = 1'b0;
        step(3);
        check("rst_cpu_rdy", cpu_rdy, 1);
        check("rst_busy", busy, 0);
        check("rst_bus_rw", bus.bus_rw, BUS_READ);
        check("rst_dmc_valid", dmc_valid, 0);
        check("rst_dmc_data", dmc_data, 0);
        n_reset = 1'b1;
        mon_en  = 1'b1;
        step(2);

        cpu_addr = 16'h8000; cpu_rw = BUS_READ; #1;
        check("idle_rd_addr", bus.bus_addr, 16'h8000);
        check("idle_rd_rw", bus.bus_rw, BUS_READ);
        check("idle_rd_rdy", cpu_rdy, 1);
        step(1);
        cpu_addr = 16'h0200; cpu_rw = BUS_WRITE; cpu_dout = 8'h55; #1;
        check("idle_wr_addr", bus.bus_addr, 16'h0200);
        check("idle_wr_rw", bus.bus_rw, BUS_WRITE);
        check("idle_wr_data", bus.bus_wdata, 8'h55);
        step(1);
        cpu_addr = 16'h8000; cpu_rw = BUS_READ;
        step(2);

        run_oam(8'h02, 1'b1, -1, 16'hC000);
        run_oam(8'h02, 1'b0, -1, 16'hC000);
        run_oam(8'h02, 1'($urandom_range(0, 1)), 'h10, 16'hC123);
        run_oam(8'h03, 1'b1, -2, 16'hC000 | 16'($urandom_range(0, 16'h3FFF)));
        run_dmc(1'b1, 16'hC000 | 16'($urandom_range(0, 16'h3FFF)));
        run_dmc(1'b0, 16'hC000 | 16'($urandom_range(0, 16'h3FFF)));
        for (int k = 0; k < 4; k++) begin
            idx_r = ($urandom_range(0, 2) != 0) ? int'($urandom_range(0, 250)) : -1;
            run_oam(8'($urandom_range(0, 8'h7F)), 1'($urandom_range(0, 1)), idx_r,
                    16'hC000 | 16'($urandom_range(0, 16'h3FFF)));
        end
        run_reset_abort(8'h05);
        run_oam(8'h06, 1'($urandom_range(0, 1)), -1, 16'hC000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apu_dma_arbiter.md
Name: apu_dma_arbiter

Overview:
- Owns the system address/data bus between the 6502 core and two DMA engines:
  - OAM sprite DMA, triggered by a CPU write to $4014.
  - DMC sample fetch, one byte per request from the APU.
- Stalls the core through cpu_rdy, sequences DMA cycles on the get/put cycle parity, and passes CPU traffic through unchanged when idle.
- Sits between cpu and the memory/PPU bus decoder.

Parameters:
- DMA_REG, 16'h4014, CPU write address that triggers OAM DMA.
- OAM_DATA, 16'h2004, OAM DMA write target address.
- OAM_LEN, 256, bytes per OAM DMA (1..256).

Ports:
- clk  in  1  system clock (one CPU cycle per clk).
- n_reset  in  1  asynchronous active-low reset.
- cpu_addr  in  16  CPU address.
- cpu_dout  in  8  CPU write data.
- cpu_rw  in  1  CPU direction, 1=read, 0=write.
- cpu_rdy  out  1  1=core may advance; 0=core frozen (clock enable).
- bus_addr  out  16  system bus address.
- bus_wdata  out  8  system bus write data.
- bus_rw  out  1  system bus direction, 1=read.
- bus_rdata  in  8  read data, valid at the clk edge ending the cycle.
- dmc_req  in  1  level request for one DMC byte.
- dmc_addr  in  16  DMC fetch address.
- dmc_data  out  8  fetched DMC byte, held until the next fetch.
- dmc_valid  out  1  one-cycle pulse: dmc_data updated.
- busy  out  1  1 whenever state != IDLE.

Behaviour:
- Reset values:
  - Outputs: cpu_rdy=1, busy=0, bus_rw=1, dmc_valid=0, dmc_data=0.
  - Internal: page=0, idx=0, data latch=0, parity=0.
  - State: IDLE.
  - Reset mid-DMA aborts immediately; no further writes occur.
- parity register toggles every clk. parity=0 is a get cycle (reads); parity=1 is a put cycle.
- States: IDLE, HALT, ALIGN, OAM_RD, OAM_WR, DMC_RD, DMC_ALIGN.
- IDLE:
  - Bus outputs equal cpu_* combinationally; cpu_rdy=1.
  - Trigger is cpu_rw=0 with cpu_addr==DMA_REG. The write still passes to the bus. page<=cpu_dout, idx<=0, oam_pend<=1, next=HALT.
  - Otherwise, if dmc_req=1, next=HALT.
- cpu_rdy=0 and busy=1 in every state other than IDLE; cpu_* inputs are ignored.
- HALT, ALIGN and DMC_ALIGN are dummy cycles: bus_addr=cpu_addr, bus_rw=1.
- HALT:
  - Lasts 1 cycle.
  - If parity=1, go to the slot decision. Otherwise go to ALIGN (1 cycle), then the slot decision.
- Slot decision (always taken into a get cycle):
  - dmc_req=1: DMC_RD.
  - Else oam_pend=1: OAM_RD.
  - Else: IDLE.
- DMC_RD:
  - Drives bus_addr=dmc_addr, bus_rw=1; dmc_data<=bus_rdata at the cycle end.
  - dmc_valid=1 in the following cycle.
  - If oam_pend=1, next=DMC_ALIGN (put dummy), then the slot decision. Otherwise next=IDLE.
  - The requester must drop dmc_req in the dmc_valid cycle. A request still high at the next decision is a new fetch.
- OAM_RD: bus_addr={page,idx}, bus_rw=1; data<=bus_rdata at the cycle end; next=OAM_WR.
- OAM_WR:
  - Drives bus_addr=OAM_DATA, bus_wdata=data, bus_rw=0.
  - If idx==OAM_LEN-1: oam_pend<=0, next=IDLE (a dmc_req then is serviced from IDLE).
  - Else: idx<=idx+1, then the slot decision.
- idx is 8-bit; page is not incremented, so an addr of {page,8'hFF} is the last byte at OAM_LEN=256.
- Stall lengths seen by the core (cycles with cpu_rdy=0):
  - OAM: 513 if HALT starts on parity=1, 514 otherwise.
  - Each DMC fetch inserted mid-OAM adds exactly 2.
  - Standalone DMC: 2 or 3.
- Simultaneous $4014 write and dmc_req in IDLE: both are accepted; DMC is served first at the first get slot.
- bus_wdata: cpu_dout when IDLE, data latch otherwise.

Decomposition:
- Shared package bus_pkg:
  - State enum dma_state_t.
  - The read/write encoding (READ=1 on bus_rw).
  - Register address constants DMA_REG and OAM_DATA.
- One natural sub-module: bus_mux, the combinational owner-select of addr/wdata/rw.
- The FSM, counters and latches stay in apu_dma_arbiter.

Test Plan:
- Idle pass-through:
  - CPU read $8000 -> bus_addr=$8000, bus_rw=1, cpu_rdy=1.
  - CPU write $0200=$55 -> bus_rw=0, bus_wdata=$55.
- OAM DMA from page $02:
  - Write $02 to $4014 with HALT on parity=1 -> 513 cycles of cpu_rdy=0.
  - Reads $0200..$02FF alternate with 256 writes to $2004; write data equals the preceding read data; busy falls with cpu_rdy rising.
- Same trigger with HALT on parity=0 -> one ALIGN dummy read at cpu_addr, 514-cycle stall, first OAM_RD on parity=0.
- dmc_req with dmc_addr=$C123 asserted during OAM byte idx=$10:
  - DMC_RD to $C123 occurs before byte $11; dmc_valid pulses once with the bus byte.
  - Total stall is 515 or 516; OAM data is uncorrupted.
- Standalone DMC: dmc_req in IDLE, HALT on parity=1 -> 2-cycle stall, one read of dmc_addr, dmc_valid one cycle later.
- n_reset low at idx=$80 -> immediately cpu_rdy=1, busy=0, bus_rw=1; after release, no $2004 write occurs until a new $4014 write.
